// File: rtl/output_buffer_pkg.sv
// Shared widths and drain FSM encodings for the accumulator result buffer.
package output_buffer_pkg;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
endpackage

// File: rtl/output_buffer.sv
// Result store behind the accumulator: per-entry valid bits plus a drain FSM that
// streams an address window to the host, stalling on entries not yet written.
module output_buffer
  import output_buffer_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              drain_start,
  input  logic [ADDR_W-1:0] drain_base,
  input  logic [ADDR_W:0]   drain_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              drain_done,
  output logic              overwrite_err,
  output logic [ADDR_W:0]   valid_count
);
  // Host handshake: a beat transfers on any posedge where out_valid && out_ready;
  // out_data/out_addr/out_last are held stable while out_valid && !out_ready.

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              out_last_q, out_last_d;
  logic              err_q, err_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              hs, wr_hit_ptr;

  assign hs         = (state_q == S_SEND) && out_valid_q && out_ready;
  assign wr_hit_ptr = wr_en && (wr_addr == ptr_q);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    case (state_q)
      S_IDLE: begin
        if (drain_start) begin
          if (drain_len == '0) begin
            state_d = S_DONE;
          end else begin
            ptr_d   = drain_base;
            rem_d   = (drain_len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : drain_len;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        // A write landing on the wanted entry this cycle is forwarded directly.
        if (vld_q[ptr_q] || wr_hit_ptr) begin
          out_data_d  = wr_hit_ptr ? wr_data : mem_q[ptr_q];
          out_addr_d  = ptr_q;
          out_last_d  = (rem_q == (ADDR_W+1)'(1));
          out_valid_d = 1'b1;
          state_d     = S_SEND;
        end
      end
      S_SEND: begin
        if (hs) begin
          out_valid_d = 1'b0;
          ptr_d       = ptr_q + ADDR_W'(1);
          rem_d       = rem_q - (ADDR_W+1)'(1);
          state_d     = (rem_q == (ADDR_W+1)'(1)) ? S_DONE : S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A write to the entry being retired in the same cycle wins and is not an overwrite.
  always_comb begin
    vld_d = vld_q;
    if (hs) vld_d[ptr_q] = 1'b0;
    if (wr_en) vld_d[wr_addr] = 1'b1;
    err_d = err_q | (wr_en && vld_q[wr_addr] && !(hs && (ptr_q == wr_addr)));
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + (ADDR_W+1)'(vld_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= '0;
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      vld_q       <= vld_d;
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
      count_q     <= count_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_addr      = out_addr_q;
  assign out_last      = out_last_q;
  assign busy          = (state_q != S_IDLE);
  assign drain_done    = (state_q == S_DONE);
  assign overwrite_err = err_q;
  assign valid_count   = count_q;
endmodule

// File: tb/tb_output_buffer.sv
// Directed bench for output_buffer: writes, drains, stalls, backpressure, overwrite and reset.
module tb_output_buffer;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          drain_start = 1'b0;
  logic [AW-1:0] drain_base = '0;
  logic [AW:0]   drain_len = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic          busy;
  logic          drain_done;
  logic          overwrite_err;
  logic [AW:0]   valid_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic          exp_last_q[$];

  output_buffer dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .drain_start(drain_start), .drain_base(drain_base), .drain_len(drain_len),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_last(out_last), .busy(busy), .drain_done(drain_done),
    .overwrite_err(overwrite_err), .valid_count(valid_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input logic [AW-1:0] a, input logic l);
    exp_q.push_back(d);
    exp_addr_q.push_back(a);
    exp_last_q.push_back(l);
  endtask

  task automatic start_drain(input logic [AW-1:0] b, input logic [AW:0] l);
    drain_start = 1'b1; drain_base = b; drain_len = l;
    @(negedge clk);
    drain_start = 1'b0;
  endtask

  task automatic collect(input int n, input bit chk_done);
    int got = 0;
    int waited = 0;
    logic [DW-1:0] ed;
    logic [AW-1:0] ea;
    logic el;
    while (got < n && waited < 100) begin
      if (out_valid && out_ready) begin
        ed = exp_q.pop_front();
        ea = exp_addr_q.pop_front();
        el = exp_last_q.pop_front();
        check("beat_data", out_data, ed);
        check("beat_addr", DW'(out_addr), DW'(ea));
        check("beat_last", DW'(out_last), DW'(el));
        got++;
        waited = 0;
      end else begin
        waited++;
      end
      @(negedge clk);
    end
    if (got < n) check("beat_timeout", DW'(got), DW'(n));
    if (chk_done) begin
      check("drain_done_pulse", DW'(drain_done), 1);
      @(negedge clk);
      check("drain_done_clear", DW'(drain_done), 0);
      check("busy_idle", DW'(busy), 0);
    end
  endtask

  task automatic wait_valid(input string tag);
    int w = 0;
    while (!out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    check(tag, DW'(out_valid), 1);
  endtask

  initial begin
    int hits;
    logic [DW-1:0] hold_d;
    logic [AW-1:0] hold_a;

    do_reset();
    check("rst_out_valid", DW'(out_valid), 0);
    check("rst_busy", DW'(busy), 0);
    check("rst_valid_count", DW'(valid_count), 0);
    check("rst_overwrite_err", DW'(overwrite_err), 0);
    check("rst_drain_done", DW'(drain_done), 0);

    // 1: basic four-entry drain
    for (int i = 0; i < 4; i++) begin
      wr(AW'(i), DW'((i + 1) * 10));
      push_beat(DW'((i + 1) * 10), AW'(i), i == 3);
    end
    check("count_after_writes", DW'(valid_count), 4);
    out_ready = 1'b1;
    start_drain(0, 4);
    check("latency_cycle1", DW'(out_valid), 0);
    @(negedge clk);
    check("latency_cycle2", DW'(out_valid), 1);
    collect(4, 1);
    check("count_after_drain", DW'(valid_count), 0);

    // 2: address wrap 14,15,0
    wr(14, 32'hA); push_beat(32'hA, 14, 0);
    wr(15, 32'hB); push_beat(32'hB, 15, 0);
    wr(0, 32'hC);  push_beat(32'hC, 0, 1);
    start_drain(14, 3);
    collect(3, 1);

    // 3: stall on empty entry, then bypass
    start_drain(5, 1);
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) hits++;
      @(negedge clk);
    end
    check("stall_no_valid", DW'(hits), 0);
    check("stall_busy", DW'(busy), 1);
    push_beat(32'h77, 5, 1);
    wr(5, 32'h77);
    check("bypass_valid", DW'(out_valid), 1);
    collect(1, 1);

    // 4: backpressure holds the beat and its valid bit
    out_ready = 1'b0;
    wr(7, 32'h1234);
    start_drain(7, 1);
    wait_valid("bp_valid");
    hold_d = out_data; hold_a = out_addr;
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!out_valid || out_data !== hold_d || out_addr !== hold_a || valid_count !== 1) hits++;
    end
    check("bp_stable", DW'(hits), 0);
    out_ready = 1'b1;
    push_beat(32'h1234, 7, 1);
    collect(1, 1);

    // 5: overwrite without drain, then write colliding with handshake
    wr(3, 1);
    wr(3, 2);
    check("overwrite_err_set", DW'(overwrite_err), 1);
    check("overwrite_count", DW'(valid_count), 1);
    push_beat(2, 3, 1);
    start_drain(3, 1);
    collect(1, 1);
    check("overwrite_sticky", DW'(overwrite_err), 1);
    do_reset();
    check("overwrite_rst", DW'(overwrite_err), 0);
    out_ready = 1'b0;
    wr(9, 32'h55);
    start_drain(9, 1);
    wait_valid("coll_valid");
    check("coll_data", out_data, 32'h55);
    out_ready = 1'b1;
    wr(9, 32'h66);
    check("coll_no_err", DW'(overwrite_err), 0);
    check("coll_count", DW'(valid_count), 1);
    check("coll_done", DW'(drain_done), 1);
    @(negedge clk);
    push_beat(32'h66, 9, 1);
    start_drain(9, 1);
    collect(1, 1);

    // 6: reset mid-drain, then zero-length drain
    for (int i = 0; i < 4; i++) wr(AW'(i), DW'(100 + i));
    push_beat(100, 0, 0);
    push_beat(101, 1, 0);
    start_drain(0, 4);
    collect(2, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_out_valid", DW'(out_valid), 0);
    check("abort_busy", DW'(busy), 0);
    check("abort_count", DW'(valid_count), 0);
    check("abort_no_done", DW'(drain_done), 0);
    @(negedge clk);
    check("abort_no_done2", DW'(drain_done), 0);
    start_drain(0, 0);
    check("len0_done", DW'(drain_done), 1);
    check("len0_no_beat", DW'(out_valid), 0);
    @(negedge clk);
    check("len0_done_clear", DW'(drain_done), 0);
    check("len0_idle", DW'(busy), 0);

    // 7: oversize length clamps to a full sweep
    for (int i = 0; i < 16; i++) begin
      wr(AW'(i), DW'($urandom_range(1, 32'hFFFF)));
      push_beat(dut.mem_q[i], AW'(i), i == 15);
    end
    check("full_count", DW'(valid_count), 16);
    start_drain(0, 20);
    collect(16, 1);
    check("clamp_count", DW'(valid_count), 0);
    check("scoreboard_empty", DW'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
